idx_map_arbiter: RTL and testbench

//  Single owner of the fifo_idx_map port. Shares it between the dispatcher's index read and the

---
 rtl/router_pkg.sv | 19 +
 rtl/rr_picker.sv | 29 ++
 rtl/idx_map_arbiter.sv | 183 ++++++++++++++++++
 tb/tb_idx_map_arbiter.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/router_pkg.sv
// Shared types for the fifo_idx_map arbiter: FSM states, default sizes and the Gray helper.
package router_pkg;

    typedef enum logic [0:0] {
        ARB     = 1'b0,
        RD_WAIT = 1'b1
    } arb_state_t;

    localparam int NPORTS_DEF = 3;
    localparam int PTR_SZ_DEF = 2;

    // Destination / map index as seen by the output ports.
    typedef logic [PTR_SZ_DEF-1:0] dest_id_t;

    function automatic logic [31:0] gray(input logic [31:0] b);
        return b ^ (b >> 1);
    endfunction

endpackage

// File: rtl/rr_picker.sv
// Combinational rotate-priority picker: first set request at or after 'start', one-hot result.
module rr_picker #(
    parameter int N  = 4,
    parameter int IW = 2
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] start,
    output logic [N-1:0]  gnt_oh,
    output logic [IW-1:0] gnt_idx,
    output logic          gnt_any
);

    always_comb begin
        int idx;
        idx     = 0;
        gnt_oh  = '0;
        gnt_idx = '0;
        gnt_any = 1'b0;
        for (int i = 0; i < N; i++) begin
            idx = (int'(start) + i) % N;
            if (!gnt_any && req[idx]) begin
                gnt_oh[idx] = 1'b1;
                gnt_idx     = IW'(idx);
                gnt_any     = 1'b1;
            end
        end
    end

endmodule

// File: rtl/idx_map_arbiter.sv
// Sole owner of the fifo_idx_map port: arbitrates the dispatcher read against port retire writes
// and owns the retire pointer. Define IDX_ARB_READ_PRIO_EN to give the reader fixed priority.
module idx_map_arbiter
    import router_pkg::*;
#(
    parameter int DEPTH  = 3,
    parameter int PTR_SZ = 2,
    parameter int NPORTS = NPORTS_DEF
) (
    input  logic                     clk2,
    input  logic                     rst,
    input  logic                     rd_req,
    input  logic [PTR_SZ-1:0]        rd_addr,
    output logic                     rd_gnt,
    output logic                     rd_data_valid,
    output logic [PTR_SZ-1:0]        rd_data,
    input  logic [NPORTS-1:0]        wr_req,
    input  logic [NPORTS*PTR_SZ-1:0] wr_data,
    output logic [NPORTS-1:0]        wr_gnt,
    output logic [PTR_SZ-1:0]        iaddr,
    output logic [PTR_SZ-1:0]        idata_wr,
    output logic                     iwrite_en,
    output logic                     iread_en,
    input  logic [PTR_SZ-1:0]        idata_rd,
    output logic [PTR_SZ-1:0]        rptr,
    output logic [PTR_SZ-1:0]        rptr_gray,
    output logic                     busy
);

    localparam int NS = NPORTS + 1;
    localparam int IW = $clog2(NS);
`ifdef IDX_ARB_READ_PRIO_EN
    localparam int NP = NPORTS;
`else
    localparam int NP = NS;
`endif

    arb_state_t          state_q, state_d;
    logic [IW-1:0]       ptr_q, ptr_d;
    logic [PTR_SZ-1:0]   rptr_q, rptr_d;
    logic [PTR_SZ-1:0]   rptr_gray_q, rptr_gray_d;
    logic [PTR_SZ-1:0]   iaddr_q, iaddr_d;
    logic [PTR_SZ-1:0]   idata_wr_q, idata_wr_d;
    logic                iwrite_en_q, iwrite_en_d;
    logic                iread_en_q, iread_en_d;
    logic [NPORTS-1:0]   wr_gnt_q, wr_gnt_d;
    logic                rd_gnt_q, rd_gnt_d;
    logic                cap_q, cap_d;
    logic [PTR_SZ-1:0]   rd_data_q, rd_data_d;
    logic                rd_data_valid_q, rd_data_valid_d;

    // Handshake: a requester holds req until it sees its 1-cycle gnt; a req still high during
    // that gnt cycle is masked out, so one request is never granted twice.
    logic [NPORTS-1:0] wr_elig;
    logic              rd_elig;
    logic [NP-1:0]     pick_req;
    logic [NP-1:0]     pick_oh;
    logic [IW-1:0]     pick_idx;
    logic              pick_any;
    logic              rd_win;
    logic [NPORTS-1:0] port_oh;
    logic              ptr_upd;

    assign wr_elig = wr_req & ~wr_gnt_q;
    assign rd_elig = rd_req & ~rd_gnt_q;

`ifdef IDX_ARB_READ_PRIO_EN
    assign pick_req = wr_elig;
    assign rd_win   = rd_elig;
    assign port_oh  = rd_elig ? '0 : pick_oh;
    assign ptr_upd  = !rd_elig && pick_any;
`else
    assign pick_req = {rd_elig, wr_elig};
    assign rd_win   = pick_oh[NPORTS];
    assign port_oh  = pick_oh[NPORTS-1:0];
    assign ptr_upd  = pick_any;
`endif

    rr_picker #(.N(NP), .IW(IW)) u_picker (
        .req     (pick_req),
        .start   (ptr_q),
        .gnt_oh  (pick_oh),
        .gnt_idx (pick_idx),
        .gnt_any (pick_any)
    );

    always_comb begin
        state_d         = state_q;
        ptr_d           = ptr_q;
        rptr_d          = rptr_q;
        iaddr_d         = iaddr_q;
        idata_wr_d      = idata_wr_q;
        iwrite_en_d     = 1'b0;
        iread_en_d      = 1'b0;
        wr_gnt_d        = '0;
        rd_gnt_d        = 1'b0;
        cap_d           = 1'b0;
        rd_data_d       = rd_data_q;
        rd_data_valid_d = 1'b0;

        // Map data appears the cycle after RD_WAIT; capture it then.
        if (cap_q) begin
            rd_data_d       = idata_rd;
            rd_data_valid_d = 1'b1;
        end

        case (state_q)
            ARB: begin
                if (ptr_upd) begin
                    ptr_d = (pick_idx == IW'(NP - 1)) ? '0 : pick_idx + 1'b1;
                end
                if (rd_win) begin
                    iaddr_d    = rd_addr;
                    iread_en_d = 1'b1;
                    rd_gnt_d   = 1'b1;
                    state_d    = RD_WAIT;
                end else if (|port_oh) begin
                    for (int p = 0; p < NPORTS; p++) begin
                        if (port_oh[p]) begin
                            idata_wr_d = wr_data[p*PTR_SZ +: PTR_SZ];
                        end
                    end
                    iaddr_d     = rptr_q;
                    iwrite_en_d = 1'b1;
                    wr_gnt_d    = port_oh;
                    rptr_d      = (rptr_q == PTR_SZ'(DEPTH - 1)) ? '0 : rptr_q + 1'b1;
                end
            end
            RD_WAIT: begin
                cap_d   = 1'b1;
                state_d = ARB;
            end
            default: state_d = ARB;
        endcase

        rptr_gray_d = PTR_SZ'(gray(32'(rptr_d)));
    end

    always_ff @(posedge clk2 or posedge rst) begin
        if (rst) begin
            state_q         <= ARB;
            ptr_q           <= '0;
            rptr_q          <= '0;
            rptr_gray_q     <= '0;
            iaddr_q         <= '0;
            idata_wr_q      <= '0;
            iwrite_en_q     <= 1'b0;
            iread_en_q      <= 1'b0;
            wr_gnt_q        <= '0;
            rd_gnt_q        <= 1'b0;
            cap_q           <= 1'b0;
            rd_data_q       <= '0;
            rd_data_valid_q <= 1'b0;
        end else begin
            state_q         <= state_d;
            ptr_q           <= ptr_d;
            rptr_q          <= rptr_d;
            rptr_gray_q     <= rptr_gray_d;
            iaddr_q         <= iaddr_d;
            idata_wr_q      <= idata_wr_d;
            iwrite_en_q     <= iwrite_en_d;
            iread_en_q      <= iread_en_d;
            wr_gnt_q        <= wr_gnt_d;
            rd_gnt_q        <= rd_gnt_d;
            cap_q           <= cap_d;
            rd_data_q       <= rd_data_d;
            rd_data_valid_q <= rd_data_valid_d;
        end
    end

    assign rd_gnt        = rd_gnt_q;
    assign rd_data_valid = rd_data_valid_q;
    assign rd_data       = rd_data_q;
    assign wr_gnt        = wr_gnt_q;
    assign iaddr         = iaddr_q;
    assign idata_wr      = idata_wr_q;
    assign iwrite_en     = iwrite_en_q;
    assign iread_en      = iread_en_q;
    assign rptr          = rptr_q;
    assign rptr_gray     = rptr_gray_q;
    assign busy          = (state_q == RD_WAIT);

endmodule

// File: tb/tb_idx_map_arbiter.sv
// Directed bench for idx_map_arbiter with a behavioural fifo_idx_map attached to the map port.
module tb_idx_map_arbiter;

    localparam int DEPTH  = 3;
    localparam int PTR_SZ = 2;
    localparam int NPORTS = 3;

    logic                     clk2;
    logic                     rst;
    logic                     rd_req;
    logic [PTR_SZ-1:0]        rd_addr;
    logic                     rd_gnt;
    logic                     rd_data_valid;
    logic [PTR_SZ-1:0]        rd_data;
    logic [NPORTS-1:0]        wr_req;
    logic [NPORTS*PTR_SZ-1:0] wr_data;
    logic [NPORTS-1:0]        wr_gnt;
    logic [PTR_SZ-1:0]        iaddr;
    logic [PTR_SZ-1:0]        idata_wr;
    logic                     iwrite_en;
    logic                     iread_en;
    logic [PTR_SZ-1:0]        idata_rd;
    logic [PTR_SZ-1:0]        rptr;
    logic [PTR_SZ-1:0]        rptr_gray;
    logic                     busy;

    int total;
    int bad;

    idx_map_arbiter #(.DEPTH(DEPTH), .PTR_SZ(PTR_SZ), .NPORTS(NPORTS)) dut (
        .clk2          (clk2),
        .rst           (rst),
        .rd_req        (rd_req),
        .rd_addr       (rd_addr),
        .rd_gnt        (rd_gnt),
        .rd_data_valid (rd_data_valid),
        .rd_data       (rd_data),
        .wr_req        (wr_req),
        .wr_data       (wr_data),
        .wr_gnt        (wr_gnt),
        .iaddr         (iaddr),
        .idata_wr      (idata_wr),
        .iwrite_en     (iwrite_en),
        .iread_en      (iread_en),
        .idata_rd      (idata_rd),
        .rptr          (rptr),
        .rptr_gray     (rptr_gray),
        .busy          (busy)
    );

    initial clk2 = 1'b0;
    always #5 clk2 = ~clk2;

    // Synchronous-read map: data valid the cycle after iread_en.
    logic [PTR_SZ-1:0] mem [4];
    always @(posedge clk2) begin
        if (iwrite_en) mem[iaddr] <= idata_wr;
        if (iread_en)  idata_rd   <= mem[iaddr];
    end

    task automatic tick();
        @(posedge clk2);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        total   = 0;
        bad     = 0;
        rst     = 1'b1;
        rd_req  = 1'b0;
        rd_addr = '0;
        wr_req  = '0;
        wr_data = '0;
        repeat (2) tick();
        chk("rst_wr_gnt", wr_gnt, 0);
        chk("rst_rd_gnt", rd_gnt, 0);
        chk("rst_rptr", rptr, 0);
        chk("rst_busy", busy, 0);
        rst = 1'b0;
        tick();

        // Single write from port 1
        wr_req  = 3'b010;
        wr_data = {2'd0, 2'd2, 2'd0};
        tick();
        chk("w1_gnt", wr_gnt, 3'b010);
        chk("w1_we", iwrite_en, 1);
        chk("w1_iaddr", iaddr, 0);
        chk("w1_idata", idata_wr, 2);
        chk("w1_rptr", rptr, 1);
        chk("w1_gray", rptr_gray, 1);
        chk("w1_rdgnt", rd_gnt, 0);
        wr_req = '0;
        tick();
        chk("w1_gnt_clr", wr_gnt, 0);
        chk("w1_we_clr", iwrite_en, 0);
        chk("w1_idata_hold", idata_wr, 2);

        // Reset while in RD_WAIT
        rd_req  = 1'b1;
        rd_addr = 2'd2;
        tick();
        chk("r0_gnt", rd_gnt, 1);
        chk("r0_busy", busy, 1);
        chk("r0_iaddr", iaddr, 2);
        rd_req = 1'b0;
        #1 rst = 1'b1;
        #1;
        chk("mr_rd_gnt", rd_gnt, 0);
        chk("mr_re", iread_en, 0);
        chk("mr_iaddr", iaddr, 0);
        chk("mr_idata", idata_wr, 0);
        chk("mr_busy", busy, 0);
        chk("mr_rptr", rptr, 0);
        chk("mr_gray", rptr_gray, 0);
        chk("mr_valid", rd_data_valid, 0);
        chk("mr_rd_data", rd_data, 0);
        tick();
        rst = 1'b0;
        tick();
        chk("mr_valid_a", rd_data_valid, 0);
        tick();
        chk("mr_valid_b", rd_data_valid, 0);

        // Three back-to-back writes wrap rptr: p0=1, p2=2, p1=3
        wr_data = {2'd2, 2'd3, 2'd1};
        wr_req  = 3'b001;
        tick();
        chk("wr0_gnt", wr_gnt, 3'b001);
        chk("wr0_iaddr", iaddr, 0);
        chk("wr0_idata", idata_wr, 1);
        chk("wr0_rptr", rptr, 1);
        chk("wr0_gray", rptr_gray, 1);
        wr_req = 3'b100;
        tick();
        chk("wr1_gnt", wr_gnt, 3'b100);
        chk("wr1_iaddr", iaddr, 1);
        chk("wr1_idata", idata_wr, 2);
        chk("wr1_rptr", rptr, 2);
        chk("wr1_gray", rptr_gray, 3);
        wr_req = 3'b010;
        tick();
        chk("wr2_gnt", wr_gnt, 3'b010);
        chk("wr2_iaddr", iaddr, 2);
        chk("wr2_idata", idata_wr, 3);
        chk("wr2_rptr", rptr, 0);
        chk("wr2_gray", rptr_gray, 0);
        wr_req = '0;
        tick();
        chk("wr_we_clr", iwrite_en, 0);

        // Read map[1] (holds 2)
        rd_req  = 1'b1;
        rd_addr = 2'd1;
        tick();
        chk("rd_gnt", rd_gnt, 1);
        chk("rd_re", iread_en, 1);
        chk("rd_iaddr", iaddr, 1);
        chk("rd_busy", busy, 1);
        chk("rd_valid_early", rd_data_valid, 0);
        rd_req = 1'b0;
        tick();
        chk("rd_gnt_clr", rd_gnt, 0);
        chk("rd_re_clr", iread_en, 0);
        chk("rd_busy_clr", busy, 0);
        chk("rd_valid_wait", rd_data_valid, 0);
        tick();
        chk("rd_valid", rd_data_valid, 1);
        chk("rd_data", rd_data, 2);
        tick();
        chk("rd_valid_clr", rd_data_valid, 0);
        chk("rd_data_hold", rd_data, 2);
        chk("rd_rptr", rptr, 0);

        // Out-of-range address passes through unmodified
        rd_req  = 1'b1;
        rd_addr = 2'd3;
        tick();
        chk("oor_gnt", rd_gnt, 1);
        chk("oor_iaddr", iaddr, 3);
        rd_req = 1'b0;
        repeat (3) tick();

        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();

        // Contention: all ports plus reader; p0 writes 3 into map[0]
        wr_data = {2'd2, 2'd1, 2'd3};
        wr_req  = 3'b111;
        rd_req  = 1'b1;
        rd_addr = 2'd0;
`ifdef IDX_ARB_READ_PRIO_EN
        tick();
        chk("c_rd_gnt", rd_gnt, 1);
        chk("c_rd_wgnt", wr_gnt, 0);
        chk("c_rd_busy", busy, 1);
        rd_req = 1'b0;
        tick();
        chk("c_wait_wgnt", wr_gnt, 0);
        chk("c_wait_rgnt", rd_gnt, 0);
        tick();
        chk("c_p0_gnt", wr_gnt, 3'b001);
        chk("c_valid", rd_data_valid, 1);
        chk("c_rd_data", rd_data, 1);
        wr_req = 3'b110;
        tick();
        chk("c_p1_gnt", wr_gnt, 3'b010);
        wr_req = 3'b100;
        tick();
        chk("c_p2_gnt", wr_gnt, 3'b100);
        chk("c_rptr", rptr, 0);
        wr_req = '0;
        tick();
        chk("c_end_wgnt", wr_gnt, 0);
        chk("c_end_rgnt", rd_gnt, 0);
`else
        tick();
        chk("c_p0_gnt", wr_gnt, 3'b001);
        chk("c_p0_rgnt", rd_gnt, 0);
        chk("c_p0_idata", idata_wr, 3);
        wr_req = 3'b110;
        tick();
        chk("c_p1_gnt", wr_gnt, 3'b010);
        chk("c_p1_rgnt", rd_gnt, 0);
        wr_req = 3'b100;
        tick();
        chk("c_p2_gnt", wr_gnt, 3'b100);
        chk("c_p2_rgnt", rd_gnt, 0);
        wr_req = '0;
        tick();
        chk("c_rd_gnt", rd_gnt, 1);
        chk("c_rd_wgnt", wr_gnt, 0);
        chk("c_rd_busy", busy, 1);
        rd_req = 1'b0;
        tick();
        chk("c_wait_wgnt", wr_gnt, 0);
        chk("c_wait_rgnt", rd_gnt, 0);
        tick();
        chk("c_valid", rd_data_valid, 1);
        chk("c_rd_data", rd_data, 3);
        chk("c_rptr", rptr, 0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
